// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle of the seven-segment scanner: frame data and load
// strobe from the counters/FSM, segment/select pins and frame marker out.
interface seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [NUM_DIGITS-1:0]   blink_in;
  logic                    lz_blank_en;
  logic                    load;
  logic [7:0]              seg_data;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_start;

  modport master (
    output digits_in, dp_in, blank_in, blink_in, lz_blank_en, load,
    input  seg_data, dig_sel, frame_start
  );

  modport slave (
    input  digits_in, dp_in, blank_in, blink_in, lz_blank_en, load,
    output seg_data, dig_sel, frame_start
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: prescaled digit scan, double-buffered
// frame load, blank/blink/dp/leading-zero rendering and a one-cycle select
// dead time at the start of each digit slot to avoid ghosting.
module seven_segment_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seven_segment_scanner_if.slave  bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = $clog2(BLINK_FRAMES + 1);
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  // One displayed image: what the shadow and active buffers hold.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0]      blink;
  } disp_t;

  disp_t                 shadow_q, shadow_d, active_q, active_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]       fc_q, fc_d;
  logic                  phase_q, phase_d;
  logic                  fs_q;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  cnt_tc, boundary, allz;
  logic [NUM_DIGITS-1:0] lz_sup, onehot;
  logic [7:0]            lit;

  // Active-high gfedcba pattern for one hex nibble.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  // Next state: scan position, frame-boundary buffer swap, blink timebase, load.
  always_comb begin
    cnt_tc    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    boundary  = cnt_tc && (idx_q == IDX_W'(NUM_DIGITS - 1));
    cnt_d     = cnt_tc ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (cnt_tc) idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    fc_d      = fc_q;
    phase_d   = phase_q;
    if (boundary) begin
      if (pending_q) active_d = shadow_q;
      pending_d = 1'b0;
      if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
        fc_d    = '0;
        phase_d = ~phase_q;
      end else begin
        fc_d    = fc_q + FC_W'(1);
      end
    end
    // A load on the boundary cycle still lands in shadow and stays pending,
    // so it is shown from the frame after the one that just started.
    if (bus.load) begin
      shadow_d.dig   = bus.digits_in;
      shadow_d.dp    = bus.dp_in;
      shadow_d.blank = bus.blank_in;
      shadow_d.blink = bus.blink_in;
      pending_d      = 1'b1;
    end
  end

  // Render the digit under scan and its select line from active data.
  always_comb begin
    allz   = 1'b1;
    lz_sup = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      allz      = allz & (active_q.dig[k] == 4'h0);
      lz_sup[k] = bus.lz_blank_en & allz;
    end
    lit = {active_q.dp[idx_q], decode(active_q.dig[idx_q])};
    if (active_q.blank[idx_q])                  lit      = '0;
    else if (active_q.blink[idx_q] && phase_q)  lit      = '0;
    else if (lz_sup[idx_q])                     lit[6:0] = '0;
    seg_d  = SEG_ACTIVE_LOW ? ~lit : lit;
    onehot = (cnt_q == '0) ? '0 : (NUM_DIGITS'(1) << idx_q);
    sel_d  = SEL_ACTIVE_LOW ? ~onehot : onehot;
  end

  // State and registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      fc_q      <= '0;
      phase_q   <= 1'b0;
      fs_q      <= 1'b0;
      seg_q     <= SEG_OFF;
      sel_q     <= SEL_OFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      fc_q      <= fc_d;
      phase_q   <= phase_d;
      fs_q      <= boundary;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.seg_data    = seg_q;
  assign bus.dig_sel     = sel_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: a frame/position based
// reference model predicts every output cycle under directed and random loads.
module tb_seven_segment_scanner;
  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * RD;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  blink;
  } img_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model: cycles since reset release, shadow/active images
  int   p;
  img_t m_sh, m_act;
  bit   m_pend;
  logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_segment_scanner_if #(.NUM_DIGITS(N)) bus ();

  seven_segment_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  function automatic logic [7:0] m_render(int k, bit ph);
    logic [7:0] lit;
    logic [3:0] nib;
    bit lz;
    nib = m_act.dig[4*k +: 4];
    lz  = bus.lz_blank_en && (k > 0);
    for (int j = k; j < N; j++) if (m_act.dig[4*j +: 4] != 4'h0) lz = 1'b0;
    if (m_act.blank[k] || (m_act.blink[k] && ph)) lit = 8'h00;
    else if (lz)                                   lit = {m_act.dp[k], 7'h00};
    else                                           lit = {m_act.dp[k], SEG_TAB[nib]};
    return ~lit;
  endfunction

  task automatic model_reset();
    p = 0; m_sh = '0; m_act = '0; m_pend = 1'b0;
  endtask

  // One clock: predict outputs for the position being rendered, clock,
  // then apply frame-boundary transfer and any load seen on that edge.
  task automatic tick(output logic [7:0] es, output logic [3:0] ed, output logic ef);
    int pos, k;
    bit ph, ld;
    img_t in_img;
    pos = p % FRAME;
    k   = pos / RD;
    ph  = (((p / FRAME) / BF) % 2) == 1;
    es  = m_render(k, ph);
    ed  = (pos % RD == 0) ? 4'hF : ~(4'b0001 << k);
    ef  = (pos == FRAME - 1);
    ld  = bus.load;
    in_img = {bus.digits_in, bus.dp_in, bus.blank_in, bus.blink_in};
    @(posedge clk);
    if (ef) begin
      if (m_pend) m_act = m_sh;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_sh = in_img; m_pend = 1'b1;
    end
    p++;
    #1;
  endtask

  task automatic test_reset();
    bus.load = 0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    bus.blink_in = '0; bus.lz_blank_en = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors += 3;
      if (bus.seg_data !== 8'hFF) begin miscompares++; $display("FAIL reset.seg got %h exp ff", bus.seg_data); end
      if (bus.dig_sel !== 4'hF) begin miscompares++; $display("FAIL reset.sel got %h exp f", bus.dig_sel); end
      if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL reset.fs got %b exp 0", bus.frame_start); end
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_idle();
    logic [7:0] es; logic [3:0] ed; logic ef;
    for (int i = 0; i < 3*FRAME; i++) begin
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL idle.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL idle.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL idle.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
  endtask

  task automatic test_double_buffer();
    logic [7:0] es; logic [3:0] ed; logic ef;
    for (int i = 0; i < 3*FRAME; i++) begin
      bus.load = (i == 5);
      if (i == 5) bus.digits_in = 16'h1D2A;
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL dbuf.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL dbuf.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL dbuf.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
    bus.load = 0;
  endtask

  task automatic test_lz();
    logic [7:0] es; logic [3:0] ed; logic ef;
    bus.lz_blank_en = 1'b1;
    for (int i = 0; i < 4*FRAME; i++) begin
      bus.load = (i == 0) || (i == FRAME) || (i == 2*FRAME);
      if (i == 0)       begin bus.digits_in = 16'h0040; bus.dp_in = 4'b0000; end
      if (i == FRAME)   begin bus.digits_in = 16'h0000; bus.dp_in = 4'b0000; end
      if (i == 2*FRAME) begin bus.digits_in = 16'h0000; bus.dp_in = 4'b0100; end
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL lz.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL lz.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL lz.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
    bus.load = 0; bus.lz_blank_en = 1'b0; bus.dp_in = '0;
  endtask

  task automatic test_blink_blank();
    logic [7:0] es; logic [3:0] ed; logic ef;
    for (int i = 0; i < 6*FRAME; i++) begin
      bus.load = (i == 0);
      if (i == 0) begin
        bus.digits_in = 16'h8765; bus.blink_in = 4'b0001; bus.blank_in = 4'b1000;
      end
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL blink.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL blink.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL blink.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
    bus.load = 0; bus.blink_in = '0; bus.blank_in = '0;
  endtask

  // Two loads in a frame, then a load on the boundary cycle itself.
  task automatic test_load_race();
    logic [7:0] es; logic [3:0] ed; logic ef;
    int base;
    base = p;
    for (int i = 0; i < 4*FRAME; i++) begin
      bus.load = 1'b0;
      case (i)
        2:         begin bus.load = 1'b1; bus.digits_in = 16'h1111; end
        9:         begin bus.load = 1'b1; bus.digits_in = 16'h2222; end
        FRAME+3:   begin bus.load = 1'b1; bus.digits_in = 16'h4444; end
        2*FRAME-1: begin bus.load = 1'b1; bus.digits_in = 16'h3333; end
        default: ;
      endcase
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL race.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL race.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL race.fs p=%0d got %b exp %b (base %0d)", p, bus.frame_start, ef, base); end
    end
    bus.load = 0;
  endtask

  task automatic test_random();
    logic [7:0] es; logic [3:0] ed; logic ef;
    for (int i = 0; i < 20*FRAME; i++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      if (bus.load) begin
        bus.digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
        bus.dp_in     = 4'($urandom);
        bus.blank_in  = 4'($urandom) & 4'($urandom);
        bus.blink_in  = 4'($urandom) & 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.lz_blank_en = ~bus.lz_blank_en;
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL rand.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL rand.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL rand.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
    bus.load = 0; bus.lz_blank_en = 0; bus.blank_in = '0; bus.blink_in = '0; bus.dp_in = '0;
  endtask

  // Reset during the digit-2 slot with a load still pending.
  task automatic test_reset_mid();
    logic [7:0] es; logic [3:0] ed; logic ef;
    int guard;
    guard = 0;
    while ((p % FRAME) != 0 && guard < FRAME) begin
      tick(es, ed, ef); guard++;
    end
    for (int i = 0; i < 2*RD + 2; i++) begin
      bus.load = (i == 0);
      if (i == 0) bus.digits_in = 16'h5A5A;
      tick(es, ed, ef);
      vectors += 1;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL rmid.pre p=%0d got %h exp %h", p, bus.seg_data, es); end
    end
    bus.load = 0;
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (bus.seg_data !== 8'hFF) begin miscompares++; $display("FAIL rmid.seg got %h exp ff", bus.seg_data); end
    if (bus.dig_sel !== 4'hF) begin miscompares++; $display("FAIL rmid.sel got %h exp f", bus.dig_sel); end
    if (bus.frame_start !== 1'b0) begin miscompares++; $display("FAIL rmid.fs got %b exp 0", bus.frame_start); end
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 2*FRAME; i++) begin
      tick(es, ed, ef);
      vectors += 3;
      if (bus.seg_data !== es) begin miscompares++; $display("FAIL rmid.post.seg p=%0d got %h exp %h", p, bus.seg_data, es); end
      if (bus.dig_sel !== ed) begin miscompares++; $display("FAIL rmid.post.sel p=%0d got %h exp %h", p, bus.dig_sel, ed); end
      if (bus.frame_start !== ef) begin miscompares++; $display("FAIL rmid.post.fs p=%0d got %b exp %b", p, bus.frame_start, ef); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_double_buffer();
    test_lz();
    test_blink_blank();
    test_load_race();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
